// File: rtl/mem_bus_arbiter.sv
// Two-master, burst-limited arbiter for the single-port word memory bus with read-data return routing.
// Optional owner lock inputs are compiled in when MEMARB_LOCK_EN is defined.
module mem_bus_arbiter #(
  parameter int MAX_BURST  = 4,
  parameter int DEF_MASTER = 0
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef MEMARB_LOCK_EN
  input  logic        m0_lock,
  input  logic        m1_lock,
`endif
  input  logic        m0_re,
  input  logic        m0_we,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m1_re,
  input  logic        m1_we,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        s_re,
  output logic        s_we,
  output logic [29:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

  owner_t        owner, owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    rd_tag;
  logic          req0, req1, cnt_full, owner_locked;

  assign req0     = m0_re | m0_we;
  assign req1     = m1_re | m1_we;
  assign cnt_full = (cnt >= CW'(MAX_BURST));

`ifdef MEMARB_LOCK_EN
  // Only the current owner's lock counts; a waiting master's lock is ignored.
  assign owner_locked = (owner == OWN_M0 && m0_lock) || (owner == OWN_M1 && m1_lock);
`else
  assign owner_locked = 1'b0;
`endif

  // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    owner_nxt = OWN_NONE;
    cnt_nxt   = '0;

    if (rst_n) begin
      if (req0 && !req1) begin
        m0_gnt = 1'b1;
      end else if (req1 && !req0) begin
        m1_gnt = 1'b1;
      end else if (req0 && req1) begin
        if (owner == OWN_NONE) begin
          m0_gnt = (DEF_MASTER == 0);
          m1_gnt = (DEF_MASTER != 0);
        end else if (owner_locked || !cnt_full) begin
          m0_gnt = (owner == OWN_M0);
          m1_gnt = (owner == OWN_M1);
        end else begin
          m0_gnt = (owner == OWN_M1);
          m1_gnt = (owner == OWN_M0);
        end
      end
    end

    if (m0_gnt) begin
      owner_nxt = OWN_M0;
      cnt_nxt   = (owner != OWN_M0) ? CW'(1) : (cnt_full ? cnt : cnt + CW'(1));
    end else if (m1_gnt) begin
      owner_nxt = OWN_M1;
      cnt_nxt   = (owner != OWN_M1) ? CW'(1) : (cnt_full ? cnt : cnt + CW'(1));
    end
  end

  always_comb begin
    s_re    = 1'b0;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (m0_gnt) begin
      s_re    = m0_re;
      s_we    = m0_we;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
    end else if (m1_gnt) begin
      s_re    = m1_re;
      s_we    = m1_we;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner  <= OWN_NONE;
      cnt    <= '0;
      rd_tag <= '0;
    end else begin
      owner  <= owner_nxt;
      cnt    <= cnt_nxt;
      rd_tag <= {s_re & m1_gnt, s_re & m0_gnt};
    end
  end

  // The bus has one read-data path; the tag decides who sees it as valid.
  assign m0_rvalid = rd_tag[0];
  assign m1_rvalid = rd_tag[1];
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed corner sequences, randomized run vs model.
// Exercises the lock feature as well when MEMARB_LOCK_EN is defined.
module tb_mem_bus_arbiter;

  localparam int MAX_BURST  = 4;
  localparam int DEF_MASTER = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_re = 0, m0_we = 0, m1_re = 0, m1_we = 0;
  logic        m0_lock = 0, m1_lock = 0;
  logic [29:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0, s_rdata = '0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_re, s_we;
  logic [31:0] m0_rdata, m1_rdata, s_wdata;
  logic [29:0] s_addr;

  int errors = 0;
  int checks = 0;

  // Reference state: owner as -1/0/1, unbounded run length, and the reads that will return next cycle.
  int own = -1;
  int streak = 0;
  bit tag0 = 0, tag1 = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_BURST(MAX_BURST), .DEF_MASTER(DEF_MASTER)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MEMARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .m0_re(m0_re), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_re(m1_re), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .s_re(s_re), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = -1; streak = 0; tag0 = 0; tag1 = 0;
  endtask

  task automatic set_req(input bit r0, input bit w0, input bit r1, input bit w1);
    m0_re = r0; m0_we = w0; m1_re = r1; m1_we = w1;
  endtask

  // Settle, compare every output against the model, advance the model, then move to the next negedge.
  // With rst_after set, reset is asserted before the coming clock edge.
  task automatic step(input bit rst_after);
    int  g;
    bit  lk;
    bit  q0, q1;
    #1;
    q0 = m0_re | m0_we;
    q1 = m1_re | m1_we;
`ifdef MEMARB_LOCK_EN
    lk = (own == 0 && m0_lock) || (own == 1 && m1_lock);
`else
    lk = 0;
`endif
    g = -1;
    if (rst_n) begin
      if (q0 && !q1) g = 0;
      else if (q1 && !q0) g = 1;
      else if (q0 && q1) begin
        if (own < 0) g = DEF_MASTER;
        else if (lk || streak < MAX_BURST) g = own;
        else g = 1 - own;
      end
    end
    check("m0_gnt", 32'(m0_gnt), 32'(g == 0));
    check("m1_gnt", 32'(m1_gnt), 32'(g == 1));
    check("s_re", 32'(s_re), 32'(g == 0 ? m0_re : g == 1 ? m1_re : 1'b0));
    check("s_we", 32'(s_we), 32'(g == 0 ? m0_we : g == 1 ? m1_we : 1'b0));
    check("s_addr", 32'(s_addr), 32'(g == 0 ? m0_addr : g == 1 ? m1_addr : 30'd0));
    check("s_wdata", s_wdata, g == 0 ? m0_wdata : g == 1 ? m1_wdata : 32'd0);
    check("m0_rvalid", 32'(m0_rvalid), 32'(tag0 && rst_n));
    check("m1_rvalid", 32'(m1_rvalid), 32'(tag1 && rst_n));
    if (m0_rvalid) check("m0_rdata", m0_rdata, s_rdata);
    if (m1_rvalid) check("m1_rdata", m1_rdata, s_rdata);
    if (!rst_n || g < 0) begin
      own = -1; streak = 0;
    end else if (g == own) begin
      streak++;
    end else begin
      own = g; streak = 1;
    end
    tag0 = rst_n && g == 0 && m0_re;
    tag1 = rst_n && g == 1 && m1_re;
    if (rst_after) begin
      rst_n = 1'b0;
      model_reset();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 0, 0, 0);
    m0_lock = 0; m1_lock = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    bit r0, w0, r1, w1;
    bit g0, g1;
  } vec_t;

  vec_t vecs[21];

  initial begin
    // Both masters write continuously: four grants each, then back to m0.
    for (int i = 0; i < 10; i++) begin
      vecs[i] = '{r0: 0, w0: 1, r1: 0, w1: 1, g0: (i < 4 || i >= 8), g1: (i >= 4 && i < 8)};
    end
    // m1 alone for ten cycles, then contention: the saturated count hands the bus to m0.
    for (int i = 10; i < 20; i++) begin
      vecs[i] = '{r0: 0, w0: 0, r1: 0, w1: 1, g0: 0, g1: 1};
    end
    vecs[20] = '{r0: 1, w0: 0, r1: 0, w1: 1, g0: 1, g1: 0};

    // Reset state, sampled with requests pending.
    set_req(1, 1, 1, 1);
    #2;
    check("rst gnt0", 32'(m0_gnt), 32'd0);
    check("rst gnt1", 32'(m1_gnt), 32'd0);
    check("rst s_re", 32'(s_re), 32'd0);
    check("rst rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    do_reset();

    m0_addr = 30'h100; m1_addr = 30'h200; m0_wdata = 32'hAAAA0000; m1_wdata = 32'hBBBB0000;
    for (int i = 0; i < 21; i++) begin
      set_req(vecs[i].r0, vecs[i].w0, vecs[i].r1, vecs[i].w1);
      #1;
      check($sformatf("vec%0d gnt0", i), 32'(m0_gnt), 32'(vecs[i].g0));
      check($sformatf("vec%0d gnt1", i), 32'(m1_gnt), 32'(vecs[i].g1));
      step(0);
    end

    // Lone read: same-cycle grant, data tagged one cycle later.
    do_reset();
    set_req(1, 0, 0, 0); m0_addr = 30'h10;
    #1;
    check("t1 gnt", 32'(m0_gnt), 32'd1);
    check("t1 s_addr", 32'(s_addr), 32'h10);
    check("t1 s_re", 32'(s_re), 32'd1);
    step(0);
    set_req(0, 0, 0, 0); s_rdata = 32'hCAFE1234;
    #1;
    check("t1 rvalid", 32'(m0_rvalid), 32'd1);
    check("t1 rdata", m0_rdata, 32'hCAFE1234);
    step(0);

    // Alternating reads: rvalid follows the issuing master, no bubble.
    set_req(1, 0, 0, 0); m0_addr = 30'h1;
    step(0);
    set_req(0, 0, 1, 0); m1_addr = 30'h2; s_rdata = 32'h11111111;
    #1;
    check("t4 m1 gnt", 32'(m1_gnt), 32'd1);
    check("t4 m0 rvalid", 32'(m0_rvalid), 32'd1);
    check("t4 m1 rvalid early", 32'(m1_rvalid), 32'd0);
    step(0);
    set_req(0, 0, 0, 0); s_rdata = 32'h22222222;
    #1;
    check("t4 m1 rvalid", 32'(m1_rvalid), 32'd1);
    check("t4 m0 rvalid late", 32'(m0_rvalid), 32'd0);
    check("t4 m1 rdata", m1_rdata, 32'h22222222);
    step(0);

    // Reset right after a read grant discards the pending return.
    set_req(1, 0, 0, 0); m0_addr = 30'h33;
    step(1);
    s_rdata = 32'hDEADBEEF;
    #1;
    check("t5 rvalid in rst", 32'(m0_rvalid), 32'd0);
    check("t5 gnt in rst", 32'(m0_gnt), 32'd0);
    step(0);
    rst_n = 1'b1; set_req(0, 0, 0, 0);
    #1;
    check("t5 rvalid after", 32'(m0_rvalid), 32'd0);
    check("t5 s_re after", 32'(s_re), 32'd0);
    check("t5 s_addr after", 32'(s_addr), 32'd0);
    step(0);
    set_req(0, 1, 0, 1);
    #1;
    check("t5 default owner", 32'({m1_gnt, m0_gnt}), (DEF_MASTER == 0) ? 32'd1 : 32'd2);
    step(0);

`ifdef MEMARB_LOCK_EN
    // Owner lock overrides the burst limit until released.
    do_reset();
    set_req(0, 1, 0, 1); m0_lock = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("lock cyc%0d", i), 32'(m0_gnt), 32'd1);
      step(0);
    end
    m0_lock = 0;
    #1;
    check("lock release", 32'(m1_gnt), 32'd1);
    step(0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_req($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      m0_addr = 30'($urandom); m1_addr = 30'($urandom);
      m0_wdata = $urandom; m1_wdata = $urandom; s_rdata = $urandom;
`ifdef MEMARB_LOCK_EN
      m0_lock = ($urandom_range(0, 4) == 0);
      m1_lock = ($urandom_range(0, 4) == 0);
`endif
      step(0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
